// File: rtl/deb_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// default timing constants derived from the 100 MHz system clock.
package deb_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } deb_state_e;

    localparam int unsigned CLK_HZ   = 100_000_000;
    localparam int unsigned DEB_10MS = CLK_HZ / 100;   // 10 ms
    localparam int unsigned LONG_2S  = 2 * CLK_HZ;     // 2 s

endpackage

// File: rtl/btn_debounce_if.sv
// Button bundle between pads and consumers.
//   btn_raw   : raw asynchronous pad levels (driven by master)
//   btn_level : debounced level (driven by slave)
//   btn_rise  : one-cycle pulse on level 0->1
//   btn_fall  : one-cycle pulse on level 1->0
//   btn_long  : one-cycle long-press pulse (0 unless BTN_LONG_PRESS_EN)
interface btn_debounce_if #(
    parameter int unsigned NUM_BTN = 4
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_rise;
    logic [NUM_BTN-1:0] btn_fall;
    logic [NUM_BTN-1:0] btn_long;

    modport master (
        output btn_raw,
        input  btn_level, btn_rise, btn_fall, btn_long
    );

    modport slave (
        input  btn_raw,
        output btn_level, btn_rise, btn_fall, btn_long
    );
endinterface

// File: rtl/btn_debounce_ch.sv
// One debounce channel: synchroniser, 4-state stability FSM, edge pulses and
// (with BTN_LONG_PRESS_EN defined) a saturating long-press detector.
//   clk100MHz, rst (async active-low)
//   btn_raw   : raw pad input
//   btn_level : debounced level
//   btn_rise / btn_fall / btn_long : one-cycle pulses
module btn_debounce_ch
    import deb_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEB_10MS,
`ifdef BTN_LONG_PRESS_EN
    parameter int unsigned LONG_PRESS_CYCLES = LONG_2S,
`endif
    parameter int unsigned SYNC_STAGES       = 2
) (
    input  logic clk100MHz,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic btn_long
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_q;

    deb_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Plain shift-register synchroniser; the last stage feeds the FSM.
    always_ff @(posedge clk100MHz or negedge rst) begin
        if (!rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign sync_q = sync_r[SYNC_STAGES-1];

    // FSM and output registers.
    always_ff @(posedge clk100MHz or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next state: any disagreement during a WAIT state drops back to the idle
    // state and clears the counter, so the counter never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (sync_q) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync_q) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IDLE_HIGH: begin
                if (!sync_q) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (sync_q) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign btn_level = level_q;
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;

`ifdef BTN_LONG_PRESS_EN
    localparam int unsigned LONG_W = $clog2(LONG_PRESS_CYCLES);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_PRESS_CYCLES - 1);

    logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
    logic              long_done_q, long_done_d;
    logic              long_q, long_d;

    always_ff @(posedge clk100MHz or negedge rst) begin
        if (!rst) begin
            long_cnt_q  <= '0;
            long_done_q <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            long_cnt_q  <= long_cnt_d;
            long_done_q <= long_done_d;
            long_q      <= long_d;
        end
    end

    // Counts only while settled high; the done flag survives a rejected
    // release glitch so one press yields at most one pulse.
    always_comb begin
        long_cnt_d  = long_cnt_q;
        long_done_d = long_done_q;
        long_d      = 1'b0;
        if (state_q == IDLE_HIGH) begin
            if (!long_done_q) begin
                if (long_cnt_q == LONG_LAST) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                end else begin
                    long_cnt_d = long_cnt_q + LONG_W'(1);
                end
            end
        end else begin
            long_cnt_d = '0;
            if (state_q == IDLE_LOW) begin
                long_done_d = 1'b0;
            end
        end
    end

    assign btn_long = long_q;
`else
    assign btn_long = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioning: NUM_BTN independent debounce channels.
// Optional long-press detection is enabled by defining BTN_LONG_PRESS_EN;
// otherwise btn_long is constant 0.
//   clk100MHz : system clock
//   rst       : asynchronous active-low reset
//   bus       : btn_debounce_if.slave (btn_raw in; level/rise/fall/long out)
module btn_debounce
    import deb_pkg::*;
#(
    parameter int unsigned NUM_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES   = DEB_10MS,
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned LONG_PRESS_CYCLES = LONG_2S
) (
    input  logic           clk100MHz,
    input  logic           rst,
    btn_debounce_if.slave  bus
);

    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] fall;
    logic [NUM_BTN-1:0] long_p;

    // Reject parameter values the channel logic cannot support.
    if (DEBOUNCE_CYCLES < 2 || SYNC_STAGES < 2 || LONG_PRESS_CYCLES < 2) begin : g_param_err
        $error("btn_debounce: DEBOUNCE_CYCLES, SYNC_STAGES, LONG_PRESS_CYCLES must be >= 2");
    end

    for (genvar i = 0; i < int'(NUM_BTN); i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
`ifdef BTN_LONG_PRESS_EN
            .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
`endif
            .SYNC_STAGES       (SYNC_STAGES)
        ) u_ch (
            .clk100MHz (clk100MHz),
            .rst       (rst),
            .btn_raw   (bus.btn_raw[i]),
            .btn_level (level[i]),
            .btn_rise  (rise[i]),
            .btn_fall  (fall[i]),
            .btn_long  (long_p[i])
        );
    end

    assign bus.btn_level = level;
    assign bus.btn_rise  = rise;
    assign bus.btn_fall  = fall;
    assign bus.btn_long  = long_p;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=8, SYNC_STAGES=2,
// LONG_PRESS_CYCLES=32 (latency 11 edges). Long-press expectations follow
// BTN_LONG_PRESS_EN.
module tb_btn_debounce;

    localparam int unsigned NB   = 4;
    localparam int unsigned DEB  = 8;
    localparam int unsigned SYNC = 2;
    localparam int unsigned LONG = 32;
    localparam int          LAT  = int'(SYNC + DEB + 1);

`ifdef BTN_LONG_PRESS_EN
    localparam logic [3:0] LONG_HIT = 4'b1001;
    localparam int         LONG_N   = 1;
`else
    localparam logic [3:0] LONG_HIT = 4'b0000;
    localparam int         LONG_N   = 0;
`endif

    logic clk100MHz = 1'b0;
    logic rst;

    always #5 clk100MHz = ~clk100MHz;

    btn_debounce_if #(.NUM_BTN(NB)) bus ();

    btn_debounce #(
        .NUM_BTN           (NB),
        .DEBOUNCE_CYCLES   (DEB),
        .SYNC_STAGES       (SYNC),
        .LONG_PRESS_CYCLES (LONG)
    ) dut (
        .clk100MHz (clk100MHz),
        .rst       (rst),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;
    int rise_cnt [NB] = '{default: 0};
    int fall_cnt [NB] = '{default: 0};
    int long_cnt [NB] = '{default: 0};

    // Pulse tally sampled mid-cycle.
    always @(negedge clk100MHz) begin
        for (int i = 0; i < int'(NB); i++) begin
            rise_cnt[i] += int'(bus.btn_rise[i]);
            fall_cnt[i] += int'(bus.btn_fall[i]);
            long_cnt[i] += int'(bus.btn_long[i]);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk100MHz);
            #1;
        end
    endtask

    initial begin
        int r1, r2, f0, f1, l0, l1, l3;

        // Reset state
        rst         = 1'b0;
        bus.btn_raw = '0;
        step(3);
        check("rst_level", 32'(bus.btn_level), 32'h0);
        check("rst_rise",  32'(bus.btn_rise),  32'h0);
        check("rst_fall",  32'(bus.btn_fall),  32'h0);
        check("rst_long",  32'(bus.btn_long),  32'h0);
        rst = 1'b1;
        step(3);

        // Clean press on channel 0
        bus.btn_raw[0] = 1'b1;
        step(LAT - 1);
        check("press_wait_level", 32'(bus.btn_level), 32'h0);
        step(1);
        check("press_level", 32'(bus.btn_level), 32'h1);
        check("press_rise",  32'(bus.btn_rise),  32'h1);
        step(1);
        check("press_rise_gone", 32'(bus.btn_rise), 32'h0);
        check("press_rise_cnt",  32'(rise_cnt[0]),  32'd1);

        // Bounce on channel 1, then hold high
        r1 = rise_cnt[1];
        for (int k = 0; k < 4; k++) begin
            bus.btn_raw[1] = (k % 2 == 0);
            step(3);
        end
        bus.btn_raw[1] = 1'b1;
        step(LAT - 1);
        check("bounce_level_wait", 32'(bus.btn_level[1]), 32'h0);
        check("bounce_no_pulse",   32'(rise_cnt[1] - r1), 32'd0);
        step(1);
        check("bounce_level", 32'(bus.btn_level[1]), 32'h1);
        check("bounce_rise",  32'(bus.btn_rise[1]),  32'h1);
        step(2);
        check("bounce_rise_cnt", 32'(rise_cnt[1] - r1), 32'd1);

        // Release of channel 0
        f0 = fall_cnt[0];
        bus.btn_raw[0] = 1'b0;
        step(LAT - 1);
        check("release_wait_level", 32'(bus.btn_level[0]), 32'h1);
        step(1);
        check("release_level", 32'(bus.btn_level[0]), 32'h0);
        check("release_fall",  32'(bus.btn_fall[0]),  32'h1);
        step(2);
        check("release_fall_cnt", 32'(fall_cnt[0] - f0), 32'd1);

        // 5-cycle low glitch on high channel 1
        f1 = fall_cnt[1];
        r1 = rise_cnt[1];
        bus.btn_raw[1] = 1'b0;
        step(5);
        bus.btn_raw[1] = 1'b1;
        step(20);
        check("glitch_level",   32'(bus.btn_level[1]), 32'h1);
        check("glitch_no_fall", 32'(fall_cnt[1] - f1), 32'd0);
        check("glitch_no_rise", 32'(rise_cnt[1] - r1), 32'd0);
        bus.btn_raw[1] = 1'b0;
        step(LAT + 2);
        check("idle_after_glitch", 32'(bus.btn_level), 32'h0);

        // Reset in the middle of a WAIT_HIGH count
        bus.btn_raw[0] = 1'b1;
        step(LAT + 1);
        check("pre_rst_level", 32'(bus.btn_level), 32'h1);
        r2 = rise_cnt[2];
        bus.btn_raw[2] = 1'b1;
        step(8);
        rst = 1'b0;
        #1;
        check("rst_async_level", 32'(bus.btn_level), 32'h0);
        step(2);
        check("rst_hold_rise", 32'(bus.btn_rise), 32'h0);
        rst = 1'b1;
        step(LAT - 1);
        check("rst_requal_wait", 32'(bus.btn_level), 32'h0);
        step(1);
        check("rst_requal_level", 32'(bus.btn_level), 32'h5);
        check("rst_requal_rise",  32'(bus.btn_rise),  32'h5);
        step(2);
        check("rst_one_rise_ch2", 32'(rise_cnt[2] - r2), 32'd1);
        bus.btn_raw = '0;
        step(LAT + 2);
        check("idle_after_rst", 32'(bus.btn_level), 32'h0);

        // Parallel press of channels 0 and 3, then long hold
        l0 = long_cnt[0];
        l1 = long_cnt[1];
        l3 = long_cnt[3];
        bus.btn_raw = 4'b1001;
        step(LAT - 1);
        check("par_wait_rise", 32'(bus.btn_rise), 32'h0);
        step(1);
        check("par_rise",  32'(bus.btn_rise),  32'h9);
        check("par_level", 32'(bus.btn_level), 32'h9);
        step(1);
        check("par_rise_gone", 32'(bus.btn_rise), 32'h0);
        step(30);
        check("long_early", 32'(bus.btn_long), 32'h0);
        step(1);
        check("long_pulse", 32'(bus.btn_long), 32'(LONG_HIT));
        step(18);
        check("long_cnt_ch0", 32'(long_cnt[0] - l0), 32'(LONG_N));
        check("long_cnt_ch3", 32'(long_cnt[3] - l3), 32'(LONG_N));
        check("long_cnt_ch1", 32'(long_cnt[1] - l1), 32'd0);
        check("long_hold_level", 32'(bus.btn_level), 32'h9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
